// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO and its read-side controllers.
//   DATA_W_DEFAULT  : default FIFO entry width
//   STATE_FILL/HOLD : encoding of the reader FSM states
//   FIFO_RD_LATENCY : cycles from pop to read data
package fifo_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 4;
    localparam int unsigned FIFO_RD_LATENCY = 1;

    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    typedef enum logic {
        StFill = STATE_FILL,
        StHold = STATE_HOLD
    } state_t;

endpackage

// File: rtl/fifo_reader.sv
// Read-side controller for the nibble FIFO: pops WORDS entries, packs them
// LSB-first into one wide word and offers it on a valid/ready handshake.
// A flush pulse emits a partial word holding whatever has been captured.
//   clk, rst_n   : clock, synchronous active-low reset
//   fifo_empty   : FIFO has no entries
//   fifo_pop     : pop request (data returns one cycle later on fifo_data)
//   fifo_data    : FIFO read data
//   flush        : emit the nibbles collected so far
//   m_data       : packed word, unused upper slots zero
//   m_count      : number of valid nibbles in m_data
//   m_valid      : m_data/m_count valid
//   m_ready      : downstream accepts the word
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned WORDS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fifo_empty,
    output logic                         fifo_pop,
    input  logic [DATA_W-1:0]            fifo_data,
    input  logic                         flush,
    output logic [DATA_W*WORDS-1:0]      m_data,
    output logic [$clog2(WORDS+1)-1:0]   m_count,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t                    state;
    logic [CNT_W-1:0]          issued;
    logic [CNT_W-1:0]          recvd;
    logic                      rd_pend;
    logic                      flush_pend;
    logic [DATA_W*WORDS-1:0]   acc;

    // A pending flush freezes pops so the word boundary stays where the flush landed.
    assign fifo_pop = (state == StFill) && !fifo_empty && (issued < WORDS_C) && !flush_pend;

    assign m_valid = (state == StHold);
    assign m_data  = m_valid ? acc : '0;
    assign m_count = m_valid ? recvd : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StFill;
            issued     <= '0;
            recvd      <= '0;
            rd_pend    <= 1'b0;
            flush_pend <= 1'b0;
            acc        <= '0;
        end else begin
            unique case (state)
                StFill: begin
                    rd_pend <= fifo_pop;
                    if (fifo_pop) begin
                        issued <= issued + ONE_C;
                    end
                    if (rd_pend) begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (recvd == CNT_W'(i)) begin
                                acc[i*DATA_W +: DATA_W] <= fifo_data;
                            end
                        end
                        recvd <= recvd + ONE_C;
                        if (recvd == LAST_C) begin
                            state <= StHold;
                        end
                    end else if (flush_pend) begin
                        // In-flight read has landed; emit partial word or drop an empty flush.
                        if (recvd != '0) begin
                            state <= StHold;
                        end else begin
                            flush_pend <= 1'b0;
                        end
                    end
                    // A new flush pulse wins over the clear above.
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                StHold: begin
                    if (m_ready) begin
                        state      <= StFill;
                        issued     <= '0;
                        recvd      <= '0;
                        flush_pend <= 1'b0;
                        acc        <= '0;
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fifo_reader;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned WORDS  = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       fifo_empty = 1'b1;
    logic                       fifo_pop;
    logic [DATA_W-1:0]          fifo_data = '0;
    logic                       flush = 1'b0;
    logic [DATA_W*WORDS-1:0]    m_data;
    logic [2:0]                 m_count;
    logic                       m_valid;
    logic                       m_ready = 1'b0;

    fifo_reader #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_data     (m_data),
        .m_count    (m_count),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench-side FIFO contents.
    logic [3:0] fifo_q[$];

    // Reference model: a word is a queue of captured nibbles.
    logic [3:0] nib_q[$];
    bit         mdl_hold;
    int         mdl_pops;
    bit         mdl_inflight;
    logic [3:0] mdl_inflight_val;
    bit         mdl_flush_wait;

    // Expected accepted words in directed tests: {count, data}.
    logic [18:0] exp_words[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mdl_word();
        logic [15:0] w = '0;
        foreach (nib_q[i]) w = w | (16'(nib_q[i]) << (4 * i));
        return w;
    endfunction

    function automatic bit mdl_pop_now();
        return !mdl_hold && (fifo_q.size() != 0) && (mdl_pops < WORDS) && !mdl_flush_wait;
    endfunction

    task automatic mdl_reset();
        nib_q.delete();
        mdl_hold       = 0;
        mdl_pops       = 0;
        mdl_inflight   = 0;
        mdl_flush_wait = 0;
    endtask

    // One clock cycle with the currently driven rst_n/flush/m_ready.
    task automatic cycle();
        bit         exp_pop;
        bit         popped = 0;
        logic [3:0] pv = '0;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        exp_pop = mdl_pop_now();
        check_eq("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        check_eq("m_valid", 32'(m_valid), 32'(mdl_hold));
        check_eq("m_data", 32'(m_data), mdl_hold ? 32'(mdl_word()) : 32'd0);
        check_eq("m_count", 32'(m_count), mdl_hold ? 32'(nib_q.size()) : 32'd0);
        if (rst_n && m_valid && m_ready && exp_words.size() != 0) begin
            logic [18:0] ew = exp_words.pop_front();
            check_eq("word_data", 32'(m_data), 32'(ew[15:0]));
            check_eq("word_count", 32'(m_count), 32'(ew[18:16]));
        end
        if (fifo_pop && fifo_q.size() != 0) begin
            pv = fifo_q.pop_front();
            popped = 1;
        end
        // Model update for this edge.
        if (!rst_n) begin
            mdl_reset();
        end else if (mdl_hold) begin
            if (m_ready) mdl_reset();
        end else begin
            if (mdl_inflight) begin
                nib_q.push_back(mdl_inflight_val);
                if (nib_q.size() == WORDS) mdl_hold = 1;
            end else if (mdl_flush_wait) begin
                if (nib_q.size() > 0) mdl_hold = 1;
                else mdl_flush_wait = 0;
            end
            if (flush) mdl_flush_wait = 1;
            if (exp_pop) mdl_pops++;
            mdl_inflight     = exp_pop;
            mdl_inflight_val = pv;
        end
        @(posedge clk);
        #1;
        fifo_data = popped ? pv : 4'($urandom);
        flush = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push4(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(v[4*i +: 4]);
    endtask

    initial begin
        mdl_reset();
        // Reset held for two cycles.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        #1;
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_data", 32'(m_data), 32'd0);
        check_eq("rst_count", 32'(m_count), 32'd0);
        check_eq("rst_pop", 32'(fifo_pop), 32'd0);

        // Full word, ready held high.
        m_ready = 1'b1;
        push4(16'h4321, 4);
        exp_words.push_back({3'd4, 16'h4321});
        run(8);

        // Backpressure, fifth entry popped after acceptance, then flushed out.
        m_ready = 1'b0;
        push4(16'hDCBA, 4);
        fifo_q.push_back(4'hE);
        exp_words.push_back({3'd4, 16'hDCBA});
        exp_words.push_back({3'd1, 16'h000E});
        run(9);
        m_ready = 1'b1;
        run(4);
        flush = 1'b1;
        run(5);

        // Empty stall mid-fill.
        push4(16'h0065, 2);
        exp_words.push_back({3'd4, 16'h8765});
        run(6);
        push4(16'h0087, 2);
        run(6);

        // Flush while the second read is in flight.
        push4(16'h00A9, 2);
        exp_words.push_back({3'd2, 16'h00A9});
        run(1);
        flush = 1'b1;
        run(6);
        // Flush with nothing captured: no word.
        flush = 1'b1;
        run(4);
        check_eq("empty_flush_valid", 32'(m_valid), 32'd0);

        // Reset after two nibbles captured.
        push4(16'h0021, 2);
        run(3);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        push4(16'hEDCB, 4);
        exp_words.push_back({3'd4, 16'hEDCB});
        run(8);
        check_eq("words_seen", 32'(exp_words.size()), 32'd0);

        // Random traffic.
        exp_words.delete();
        for (int i = 0; i < 3000; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back(4'($urandom));
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the team's 4-bit nibble FIFO. It issues pops, captures the returned nibbles and packs `WORDS` of them into one wide word. It presents that word downstream on a valid/ready handshake. It sits between the FIFO's pop port and any wide consumer, and it supports a flush that emits a partial word.

## Interface
Parameters:
- `DATA_W`, default 4: FIFO entry width in bits.
- `WORDS`, default 4: FIFO entries packed per output word; must be at least 2.

Ports:
- `clk`  in  1  The single clock. All state changes on the rising edge.
- `rst_n`  in  1  Synchronous, active-low reset, sampled on the rising edge of `clk`.
- `fifo_empty`  in  1  FIFO has no entries.
- `fifo_pop`  out  1  Pop request to the FIFO.
- `fifo_data`  in  DATA_W  FIFO read data. Valid in the cycle after `fifo_pop` is high.
- `flush`  in  1  Single-cycle pulse: emit the nibbles collected so far as a partial word.
- `m_data`  out  DATA_W*WORDS  Packed word. The first nibble popped goes in the least significant bits.
- `m_count`  out  $clog2(WORDS+1)  Number of valid nibbles in `m_data`.
- `m_valid`  out  1  `m_data` and `m_count` are valid.
- `m_ready`  in  1  Downstream accepts the word.

## Operation
- Registers:
  - `issued` counter: pops sent for the current word.
  - `recvd` counter: nibbles captured for the current word.
  - `rd_pend` flag: a pop was issued last cycle, so its data arrives this cycle.
  - `flush_pend` flag: a flush is waiting to be acted on.
  - `acc` accumulator, DATA_W*WORDS bits.
- States:
  - FILL: collecting nibbles.
  - HOLD: word presented downstream.
- `fifo_pop` is combinational and equals (state==FILL) && !fifo_empty && (issued<WORDS) && !flush_pend.
  - A pop is never issued while the FIFO is empty.
- Capture: when `rd_pend` is high, write `fifo_data` into slot `recvd` of `acc`, then increment `recvd`.
- FILL → HOLD, in either case:
  - on the edge where `recvd` reaches WORDS;
  - or when `flush_pend` is set, `rd_pend` is low, and `recvd` > 0.
- HOLD → FILL on m_valid && m_ready. On that edge, clear `issued`, `recvd`, `acc` and `flush_pend`.
- Flush behaviour:
  - A flush in FILL sets `flush_pend`, which blocks further pops.
  - A read already in flight completes first; the flush then takes effect.
  - A flush with `recvd`==0 and no read in flight is ignored, and `flush_pend` is cleared.
  - A flush in HOLD is ignored.
- Partial word: unused upper slots of `m_data` are zero, and `m_count`=`recvd`.
- Full word: `m_count`=WORDS.
- Outputs in HOLD: `m_valid`=1, and `m_data`/`m_count` stay stable until accepted. `m_ready` is ignored in FILL.
- Reset (mid-operation included):
  - state returns to FILL;
  - all counters, flags and `acc` are cleared;
  - `m_valid`=0, `m_data`=0, `m_count`=0;
  - an in-flight read is discarded.

## Timing
- FIFO read latency is fixed at 1: a pop in cycle t returns data in cycle t+1.
- Best-case latency with the FIFO holding at least WORDS entries:
  - pops in cycles 0..WORDS-1;
  - last capture at the edge ending cycle WORDS;
  - `m_valid` high in cycle WORDS+1.
- Throughput: after acceptance in cycle k, the next pop can issue in cycle k+1. With WORDS=4 that gives one word every 6 cycles.
- Empty mid-fill: pops stop, captured nibbles are held, and filling resumes in the first cycle that `fifo_empty` is low.
- `fifo_empty` and `flush` arriving in the same cycle: no pop; `flush_pend` is set.

## Structure
- Shared package `fifo_pkg` holds:
  - `DATA_W` default;
  - the FILL/HOLD state encoding as localparams;
  - the FIFO read-latency constant (1).
- No sub-module: the counters, flags and accumulator fit inline in a single always block plus the combinational pop logic.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles → `m_valid`=0, `m_data`=0, `m_count`=0, `fifo_pop`=0.
- Full word, `m_ready` held high:
  - stimulus: FIFO preloaded with 1,2,3,4;
  - expected: `fifo_pop` high in cycles 0–3; `m_data`=16'h4321 and `m_count`=4 in cycle 5; acceptance in cycle 5.
- Backpressure:
  - stimulus: FIFO preloaded with A,B,C,D,E; `m_ready` low for 3 cycles;
  - expected: 16'hDCBA held stable; no pop while in HOLD; E is popped in the cycle after acceptance.
- Empty stall:
  - stimulus: FIFO holds 2 entries (5,6); `fifo_empty` rises; entries 7,8 arrive 4 cycles later;
  - expected: no pop while empty; final word 16'h8765.
- Flush with a read in flight:
  - stimulus: entries 9,A; flush pulsed in the cycle A is popped;
  - expected: `m_data`=16'h00A9, `m_count`=2; flush with `recvd`=0 produces no output.
- Reset mid-fill:
  - stimulus: `rst_n` low after 2 nibbles captured;
  - expected: state cleared; the next 4 entries form a fresh word with no stale nibbles.
